// File: rtl/fc_result_reader.sv
// rtl/fc_result_reader.sv - reads FC2 class scores from SRAM f, streams them out, reports arg-max
// Fetches one packed word per group of scores and tracks the signed maximum as beats are accepted.
module fc_result_reader #(
  parameter int DATA_WIDTH             = 8,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int CLASS_NUM              = 10,
  localparam int WORD_W   = DATA_WIDTH * DATA_NUM_PER_SRAM_ADDR,
  localparam int WORD_NUM = (CLASS_NUM + DATA_NUM_PER_SRAM_ADDR - 1) / DATA_NUM_PER_SRAM_ADDR,
  localparam int ADDR_W   = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1,
  localparam int IDX_W    = $clog2(CLASS_NUM),
  localparam int LANE_W   = (DATA_NUM_PER_SRAM_ADDR > 1) ? $clog2(DATA_NUM_PER_SRAM_ADDR) : 1
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  fc2_done,
  output logic [ADDR_W-1:0]     sram_raddr_f,
  input  logic [WORD_W-1:0]     sram_rdata_f,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [IDX_W-1:0]      result_index,
  output logic                  result_last,
  output logic                  class_valid,
  output logic [IDX_W-1:0]      class_id,
  output logic [DATA_WIDTH-1:0] class_score,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LATCH  = 3'd2,
    SEND   = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0]      max_id_q, max_id_d;
  logic [DATA_WIDTH-1:0] score;
  logic                  is_last;
  logic                  lane_wrap;

  // Lane 0 occupies the most significant byte of the word.
  always_comb begin
    score = '0;
    for (int l = 0; l < DATA_NUM_PER_SRAM_ADDR; l++) begin
      if (lane_q == LANE_W'(l)) begin
        score = word_q[(DATA_NUM_PER_SRAM_ADDR-1-l)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign is_last   = (idx_q == IDX_W'(CLASS_NUM - 1));
  assign lane_wrap = (lane_q == LANE_W'(DATA_NUM_PER_SRAM_ADDR - 1));

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    word_d   = word_q;
    max_d    = max_q;
    max_id_d = max_id_q;
    case (state_q)
      IDLE: begin
        if (fc2_done) begin
          waddr_d  = '0;
          idx_d    = '0;
          lane_d   = '0;
          max_d    = '0;
          max_id_d = '0;
          state_d  = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        word_d  = sram_rdata_f;
        state_d = SEND;
      end
      SEND: begin
        if (result_ready) begin
          // Strict compare keeps the lowest index on ties.
          if ((idx_q == '0) || ($signed(score) > $signed(max_q))) begin
            max_d    = score;
            max_id_d = idx_q;
          end
          idx_d  = idx_q + 1'b1;
          lane_d = lane_wrap ? '0 : lane_q + 1'b1;
          if (is_last) begin
            state_d = REPORT;
          end else if (lane_wrap) begin
            waddr_d = waddr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      word_q   <= '0;
      max_q    <= '0;
      max_id_q <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      max_q    <= max_d;
      max_id_q <= max_id_d;
    end
  end

  assign sram_raddr_f = waddr_q;
  assign result_valid = (state_q == SEND);
  assign result_data  = result_valid ? score : '0;
  assign result_index = result_valid ? idx_q : '0;
  assign result_last  = result_valid && is_last;
  assign class_valid  = (state_q == REPORT);
  assign class_id     = max_id_q;
  assign class_score  = max_q;
  assign busy         = (state_q != IDLE);

endmodule
